// File: rtl/line_assembler_pkg.sv
// term_pkg: byte constants, screen geometry and assembler state encoding shared with the text writer
package term_pkg;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_BS  = 8'h08;
  localparam logic [7:0] CHR_DEL = 8'h7F;
  localparam logic [7:0] CHR_SP  = 8'h20;
  localparam int TERM_COLS = 80;
  localparam int TERM_ROWS = 30;
  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    WAIT_ROOM = 2'd1,
    EMIT      = 2'd2
  } state_t;
endpackage

// File: rtl/line_assembler_if.sv
// line_assembler_if: UART byte input (i_rx_data/i_rx_valid), consumer full flag (i_full) and packed-line output (o_data/o_ena/o_len) plus status (o_busy/o_drop); slave = assembler side
interface line_assembler_if #(
  parameter int MAX_COLS = 80,
  parameter int LEN_W    = 7
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic                  i_full;
  logic [8*MAX_COLS-1:0] o_data;
  logic                  o_ena;
  logic [LEN_W-1:0]      o_len;
  logic                  o_busy;
  logic                  o_drop;
  modport slave (input i_rx_data, i_rx_valid, i_full, output o_data, o_ena, o_len, o_busy, o_drop);
  modport master(output i_rx_data, i_rx_valid, i_full, input o_data, o_ena, o_len, o_busy, o_drop);
endinterface

// File: rtl/line_assembler_char_classify.sv
// char_classify: sorts a received byte into printable / backspace / line terminator (i_byte in; o_is_print, o_is_bs, o_is_term out)
module char_classify
  import term_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_print,
  output logic       o_is_bs,
  output logic       o_is_term
);
  assign o_is_print = i_byte[7] || (i_byte >= CHR_SP && i_byte < CHR_DEL);
  assign o_is_bs    = i_byte == CHR_BS || i_byte == CHR_DEL;
  assign o_is_term  = i_byte == CHR_LF || i_byte == CHR_CR;
endmodule

// File: rtl/line_assembler.sv
// line_assembler: collects UART bytes into a line buffer and emits it as a packed word with a held enable (i_clk, clean sync reset, bus = slave side of line_assembler_if)
module line_assembler
  import term_pkg::*;
#(
  parameter int MAX_COLS    = TERM_COLS,
  parameter int HOLD_CYCLES = 8,
  parameter int LEN_W       = 7
) (
  input  logic               i_clk,
  input  logic               clean,
  line_assembler_if.slave    bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_t                r_state;
  logic [8*MAX_COLS-1:0] r_data;
  logic [LEN_W-1:0]      r_len;
  logic [HW-1:0]         r_hold;
  logic                  r_ena;
  logic                  r_drop;
  logic                  w_is_print, w_is_bs, w_is_term;
  logic [LEN_W-1:0]      w_len_inc, w_len_dec;
  logic                  w_busy;
  char_classify u_cls (
    .i_byte    (bus.i_rx_data),
    .o_is_print(w_is_print),
    .o_is_bs   (w_is_bs),
    .o_is_term (w_is_term)
  );
  assign w_len_inc = r_len + 1'b1;
  assign w_len_dec = r_len - 1'b1;
  assign w_busy    = r_state != COLLECT;
  always_ff @(posedge i_clk) begin
    r_drop <= !clean && bus.i_rx_valid && w_busy;
    if (clean) begin
      r_state <= COLLECT;
      r_data  <= '0;
      r_len   <= '0;
      r_hold  <= '0;
      r_ena   <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: if (bus.i_rx_valid) begin
          if (w_is_print || w_is_term) begin
            // terminators are normalised to LF so the consumer sees one line-end code
            r_data[{r_len, 3'b000} +: 8] <= w_is_term ? CHR_LF : bus.i_rx_data;
            r_len <= w_len_inc;
            if (w_is_term || w_len_inc == LEN_W'(MAX_COLS)) begin
              r_state <= bus.i_full ? WAIT_ROOM : EMIT;
              r_ena   <= !bus.i_full;
              r_hold  <= '0;
            end
          end else if (w_is_bs && r_len != '0) begin
            r_data[{w_len_dec, 3'b000} +: 8] <= 8'h00;
            r_len <= w_len_dec;
          end
        end
        WAIT_ROOM: if (!bus.i_full) begin
          r_state <= EMIT;
          r_ena   <= 1'b1;
          r_hold  <= '0;
        end
        EMIT: if (r_hold == HW'(HOLD_CYCLES - 1)) begin
          r_state <= COLLECT;
          r_ena   <= 1'b0;
          r_data  <= '0;
          r_len   <= '0;
          r_hold  <= '0;
        end else begin
          r_hold <= r_hold + 1'b1;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end
  assign bus.o_data = r_data;
  assign bus.o_len  = r_len;
  assign bus.o_ena  = r_ena;
  assign bus.o_busy = w_busy;
  assign bus.o_drop = r_drop;
endmodule

// File: tb/tb_line_assembler.sv
// tb_line_assembler: directed stimulus with an expected-line queue checked by a separate output monitor
module tb_line_assembler;
  logic clk = 1'b0;
  logic clean = 1'b1;
  always #5 clk = ~clk;
  line_assembler_if bus ();
  line_assembler dut (
    .i_clk(clk),
    .clean(clean),
    .bus  (bus.slave)
  );
  typedef struct {
    int           len;
    logic [639:0] data;
    int           hold;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   run = 0;
  logic prev_ena = 1'b0;
  task automatic chk(string n, logic [639:0] act, logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic push_line(int len, logic [639:0] data, int hold);
    exp_t e;
    e.len  = len;
    e.data = data;
    e.hold = hold;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (bus.o_ena && !prev_ena) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_line: got len %0d want no emission", bus.o_len);
        cur.len = int'(bus.o_len);
        cur.data = bus.o_data;
        cur.hold = 8;
      end else begin
        cur = exp_q.pop_front();
        chk("line_len", 640'(bus.o_len), 640'(cur.len));
      end
      run = 1;
    end else if (bus.o_ena) begin
      run++;
    end else if (prev_ena) begin
      chk("hold_cycles", 640'(run), 640'(cur.hold));
    end
    if (bus.o_ena) chk("line_data", bus.o_data, cur.data);
    prev_ena = bus.o_ena;
  end
  task automatic send(logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((bus.o_ena || bus.o_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 640'(n < 200), 640'(1));
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_full     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ena", 640'(bus.o_ena), 640'(0));
    chk("rst_len", 640'(bus.o_len), 640'(0));
    chk("rst_data", bus.o_data, 640'(0));
    chk("rst_busy", 640'(bus.o_busy), 640'(0));
    chk("rst_drop", 640'(bus.o_drop), 640'(0));
    clean = 1'b0;
    push_line(3, 640'h0A6948, 8);
    send(8'h48);
    repeat (3) @(negedge clk);
    send(8'h69);
    repeat (3) @(negedge clk);
    chk("hi_partial_len", 640'(bus.o_len), 640'(2));
    send(8'h0A);
    chk("hi_latency_ena", 640'(bus.o_ena), 640'(1));
    chk("hi_busy", 640'(bus.o_busy), 640'(1));
    wait_idle();
    chk("hi_len_cleared", 640'(bus.o_len), 640'(0));
    send(8'h08);
    chk("bs_empty_len", 640'(bus.o_len), 640'(0));
    repeat (3) @(negedge clk);
    chk("bs_empty_ena", 640'(bus.o_ena), 640'(0));
    push_line(3, 640'h0A6361, 8);
    send(8'h61);
    send(8'h62);
    chk("ab_len", 640'(bus.o_len), 640'(2));
    chk("ab_nodrop", 640'(bus.o_drop), 640'(0));
    send(8'h7F);
    chk("bs_len", 640'(bus.o_len), 640'(1));
    chk("bs_cleared", 640'(bus.o_data[15:8]), 640'(0));
    send(8'h63);
    send(8'h0D);
    wait_idle();
    for (int i = 0; i < 79; i++) send(8'h78);
    chk("x79_len", 640'(bus.o_len), 640'(79));
    chk("x79_busy", 640'(bus.o_busy), 640'(0));
    push_line(80, {80{8'h78}}, 8);
    send(8'h78);
    chk("x80_ena", 640'(bus.o_ena), 640'(1));
    send(8'h79);
    chk("x81_drop", 640'(bus.o_drop), 640'(1));
    wait_idle();
    chk("x_len_cleared", 640'(bus.o_len), 640'(0));
    push_line(1, 640'h0A, 8);
    send(8'h0A);
    wait_idle();
    bus.i_full = 1'b1;
    push_line(1, 640'h0A, 8);
    send(8'h0A);
    chk("full_busy", 640'(bus.o_busy), 640'(1));
    repeat (3) @(negedge clk);
    chk("full_ena_low", 640'(bus.o_ena), 640'(0));
    bus.i_full = 1'b0;
    @(negedge clk);
    chk("room_ena", 640'(bus.o_ena), 640'(1));
    chk("room_len", 640'(bus.o_len), 640'(1));
    wait_idle();
    push_line(2, 640'h0A51, 4);
    send(8'h51);
    send(8'h0A);
    repeat (3) @(negedge clk);
    clean = 1'b1;
    @(negedge clk);
    clean = 1'b0;
    chk("abort_ena", 640'(bus.o_ena), 640'(0));
    chk("abort_len", 640'(bus.o_len), 640'(0));
    chk("abort_data", bus.o_data, 640'(0));
    chk("abort_busy", 640'(bus.o_busy), 640'(0));
    push_line(2, 640'h0A41, 8);
    send(8'h41);
    send(8'h0A);
    wait_idle();
    send(8'h07);
    chk("ctrl_ignored", 640'(bus.o_len), 640'(0));
    push_line(2, 640'h0A5A, 8);
    send(8'h5A);
    send(8'h0A);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("queue_empty", 640'(exp_q.size()), 640'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
